// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display blocks.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package display_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg7_t;     // {a,b,c,d,e,f,g}, a = bit 6, active-low

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t SEG_DIGIT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    // Binary to packed BCD, up to 8 digits; used only on parameters.
    function automatic logic [31:0] to_bcd(input int unsigned value);
        int unsigned v;
        logic [31:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_updown_display_if.sv
// Bundle between the push-buttons/display bank and the counter-display block.
// Latency: n/a (wires only).
// Backpressure: none; buttons are free-running levels, outputs are always valid.
// Ports: increment/decrease (button levels), count_bcd, wrap, seg, digit_en.
interface bcd_updown_display_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 2
) ();

    logic                      increment;
    logic                      decrease;
    logic [4*NUM_DIGITS-1:0]   count_bcd;
    logic                      wrap;
    seg7_t                     seg;
    logic [NUM_DIGITS-1:0]     digit_en;

    // master: board side driving buttons and watching the display
    modport master (
        output increment, decrease,
        input  count_bcd, wrap, seg, digit_en
    );

    // slave: the counter/display block
    modport slave (
        input  increment, decrease,
        output count_bcd, wrap, seg, digit_en
    );

endinterface

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern, with forced blank.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (digit), blank (force all segments off), seg (pattern out).
module seg7_decode
    import display_pkg::*;
(
    input  bcd_t  bcd,
    input  logic  blank,
    output seg7_t seg
);

    always_comb begin
        seg = SEG_BLANK;
        // codes 10..15 are not digits and show as blank
        if (!blank && (bcd < 4'd10)) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/bcd_updown_display.sv
// Up/down BCD counter driven by button edges, with multiplexed 7-segment scan.
// Latency: button edge registered at edge N -> count at N+2 -> seg/digit_en at N+3.
// Backpressure: none; every detected edge is acted on, bounces included.
// Ports: clk, reset (sync, active-high), bus (slave: buttons in, count/wrap/display out).
module bcd_updown_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_VALUE  = 63,
    parameter int WRAP       = 1,
    parameter int SCAN_DIV   = 50000,
    parameter int LZ_BLANK   = 1
) (
    input  logic clk,
    input  logic reset,
    bcd_updown_display_if.slave bus
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] MAX_BCD  = CW'(to_bcd(MAX_VALUE));
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // ---------------- button synchronisers and edge detect ----------------
    // [0],[1] form the synchroniser, [2] is the delay flop for edge detect.
    logic [2:0] inc_sync;
    logic [2:0] dec_sync;
    logic       up_p;
    logic       dn_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            inc_sync <= '0;
            dec_sync <= '0;
        end else begin
            inc_sync <= {inc_sync[1:0], bus.increment};
            dec_sync <= {dec_sync[1:0], bus.decrease};
        end
    end

    assign up_p = inc_sync[1] & ~inc_sync[2];
    assign dn_p = dec_sync[1] & ~dec_sync[2];

    // ---------------- BCD +1 / -1 with ripple carry/borrow ----------------
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         inc_val;
    logic [CW-1:0]         dec_val;
    logic [NUM_DIGITS-1:0] carry;       // carry into digit i
    logic [NUM_DIGITS-1:0] borrow;      // borrow into digit i
    logic [NUM_DIGITS-1:0] upper_zero;  // digits i and above are all zero
    bcd_t                  digit [NUM_DIGITS];

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign digit[i] = count_q[4*i +: 4];

        assign inc_val[4*i +: 4] = !carry[i]            ? digit[i] :
                                   (digit[i] == 4'd9)   ? 4'd0     : digit[i] + 4'd1;
        assign dec_val[4*i +: 4] = !borrow[i]           ? digit[i] :
                                   (digit[i] == 4'd0)   ? 4'd9     : digit[i] - 4'd1;

        assign upper_zero[i] = (count_q[CW-1:4*i] == '0);

        if (i < NUM_DIGITS - 1) begin : g_chain
            assign carry[i+1]  = carry[i]  & (digit[i] == 4'd9);
            assign borrow[i+1] = borrow[i] & (digit[i] == 4'd0);
        end
    end

    // ---------------- count register ----------------
    logic wrap_q;
    logic at_max;
    logic at_zero;

    assign at_max  = (count_q == MAX_BCD);
    assign at_zero = (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            // simultaneous up and down cancel out
            if (up_p && !dn_p) begin
                if (at_max) begin
                    wrap_q <= 1'b1;
                    if (WRAP != 0) count_q <= '0;
                end else begin
                    count_q <= inc_val;
                end
            end else if (dn_p && !up_p) begin
                if (at_zero) begin
                    wrap_q <= 1'b1;
                    if (WRAP != 0) count_q <= MAX_BCD;
                end else begin
                    count_q <= dec_val;
                end
            end
        end
    end

    // ---------------- digit scan ----------------
    logic [PW-1:0]         pre_q;
    logic [IW-1:0]         idx_q;
    seg7_t                 seg_q;
    seg7_t                 seg_d;
    logic [NUM_DIGITS-1:0] en_q;
    logic                  lz;

    // digit 0 is always shown so a zero count still displays "0"
    assign lz = (LZ_BLANK != 0) && (idx_q != '0) && upper_zero[idx_q];

    seg7_decode u_dec (
        .bcd   (digit[idx_q]),
        .blank (lz),
        .seg   (seg_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            en_q  <= '1;
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                pre_q <= pre_q + PW'(1);
            end
            // seg and enable both come from the same idx, so they stay aligned
            seg_q <= seg_d;
            en_q  <= ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.seg       = seg_q;
    assign bus.digit_en  = en_q;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Bench for bcd_updown_display: two instances (wrap + leading-zero blank, saturate + no blank)
// share the same button stimulus; expectations come from tables and a decimal reference model.
module tb_bcd_updown_display;

    localparam int ND   = 2;
    localparam int MAXV = 63;
    localparam int SDIV = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic inc   = 1'b0;
    logic dec   = 1'b0;

    always #5 clk = ~clk;

    bcd_updown_display_if #(.NUM_DIGITS(ND)) ifa ();
    bcd_updown_display_if #(.NUM_DIGITS(ND)) ifb ();

    assign ifa.increment = inc;
    assign ifa.decrease  = dec;
    assign ifb.increment = inc;
    assign ifb.decrease  = dec;

    bcd_updown_display #(
        .NUM_DIGITS(ND), .MAX_VALUE(MAXV), .WRAP(1), .SCAN_DIV(SDIV), .LZ_BLANK(1)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    bcd_updown_display #(
        .NUM_DIGITS(ND), .MAX_VALUE(MAXV), .WRAP(0), .SCAN_DIV(SDIV), .LZ_BLANK(0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int checks = 0;
    int errors = 0;
    int mod_a  = 0;   // decimal value expected in dut_a
    int mod_b  = 0;   // decimal value expected in dut_b

    typedef struct {
        bit up;
        bit dn;
        int ea;
        int eb;
        bit wa;
        bit wb;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd8(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] code_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit lz);
        int p;
        p = (idx == 0) ? 1 : 10;
        if (lz && idx > 0 && (v / p) == 0) return 7'b1111111;
        return code_of((v / p) % 10);
    endfunction

    function automatic int model_next(input int v, input bit up, input bit dn,
                                      input bit wrapmode, output bit w);
        w = 1'b0;
        if (up && !dn) begin
            if (v == MAXV) begin
                w = 1'b1;
                return wrapmode ? 0 : v;
            end
            return v + 1;
        end
        if (dn && !up) begin
            if (v == 0) begin
                w = 1'b1;
                return wrapmode ? MAXV : 0;
            end
            return v - 1;
        end
        return v;
    endfunction

    // All tasks are entered and left 1 time unit after a rising clk edge.
    task automatic step_exp(input bit up, input bit dn, input int ea, input int eb,
                            input bit wa, input bit wb, input string tag);
        inc = up;
        dec = dn;
        @(posedge clk);             // edge N: level registered
        @(posedge clk); #1;         // edge N+1: count must not have moved yet
        chk({tag, "_a_early"}, 32'(ifa.count_bcd), 32'(to_bcd8(mod_a)));
        chk({tag, "_b_early"}, 32'(ifb.count_bcd), 32'(to_bcd8(mod_b)));
        @(posedge clk); #1;         // edge N+2: count updated, wrap pulse
        chk({tag, "_a_cnt"},  32'(ifa.count_bcd), 32'(to_bcd8(ea)));
        chk({tag, "_b_cnt"},  32'(ifb.count_bcd), 32'(to_bcd8(eb)));
        chk({tag, "_a_wrap"}, 32'(ifa.wrap), 32'(wa));
        chk({tag, "_b_wrap"}, 32'(ifb.wrap), 32'(wb));
        @(posedge clk); #1;
        chk({tag, "_a_wrap_end"}, 32'(ifa.wrap), 32'd0);
        chk({tag, "_b_wrap_end"}, 32'(ifb.wrap), 32'd0);
        inc = 1'b0;
        dec = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mod_a = ea;
        mod_b = eb;
    endtask

    task automatic step_model(input bit up, input bit dn, input string tag);
        int ea;
        int eb;
        bit wa;
        bit wb;
        ea = model_next(mod_a, up, dn, 1'b1, wa);
        eb = model_next(mod_b, up, dn, 1'b0, wb);
        step_exp(up, dn, ea, eb, wa, wb, tag);
    endtask

    task automatic check_display(input bit sel, input string tag);
        logic [1:0] en;
        logic [6:0] sg;
        int         v;
        bit         lz;
        for (int c = 0; c < 2 * SDIV + 1; c++) begin
            @(posedge clk); #1;
            en = sel ? ifb.digit_en : ifa.digit_en;
            sg = sel ? ifb.seg      : ifa.seg;
            v  = sel ? mod_b        : mod_a;
            lz = !sel;
            if (en == 2'b10)      chk({tag, "_dig0"}, 32'(sg), 32'(exp_seg(v, 0, lz)));
            else if (en == 2'b01) chk({tag, "_dig1"}, 32'(sg), 32'(exp_seg(v, 1, lz)));
            else                  chk({tag, "_en_onehot"}, 32'(en), 32'b10);
        end
    endtask

    task automatic check_period(input string tag);
        logic [1:0] prev;
        int         n;
        prev = ifa.digit_en;
        n    = 0;
        while (ifa.digit_en == prev && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 2; k++) begin
            prev = ifa.digit_en;
            n    = 0;
            while (ifa.digit_en == prev && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk({tag, "_slot_len"}, 32'(n), 32'(SDIV));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inc   = 1'b0;
        dec   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mod_a = 0;
        mod_b = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_cnt"},  32'(ifa.count_bcd), 32'd0);
        chk({tag, "_b_cnt"},  32'(ifb.count_bcd), 32'd0);
        chk({tag, "_a_wrap"}, 32'(ifa.wrap), 32'd0);
        chk({tag, "_b_wrap"}, 32'(ifb.wrap), 32'd0);
        chk({tag, "_a_seg"},  32'(ifa.seg), 32'h7F);
        chk({tag, "_b_seg"},  32'(ifb.seg), 32'h7F);
        chk({tag, "_a_en"},   32'(ifa.digit_en), 32'b11);
        chk({tag, "_b_en"},   32'(ifb.digit_en), 32'b11);
    endtask

    initial begin
        int ea;
        int eb;
        bit wa;
        bit wb;
        int wcnt_a;
        int wcnt_b;

        // {up, dn, expected A, expected B, wrap A, wrap B}, applied from a reset count of 0
        tbl[0] = '{1'b0, 1'b1, 63, 0, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0,  0, 1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1,  0, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0,  1, 2, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1,  0, 1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 63, 0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 62, 0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 63, 1, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0,  0, 2, 1'b1, 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step_exp(tbl[i].up, tbl[i].dn, tbl[i].ea, tbl[i].eb, tbl[i].wa, tbl[i].wb,
                     $sformatf("tbl%0d", i));
        end

        // 12 presses -> 12, then check the scanned display and slot length
        do_reset();
        for (int i = 0; i < 12; i++) step_model(1'b1, 1'b0, "inc12");
        chk("inc12_a_value", 32'(ifa.count_bcd), 32'h12);
        check_display(1'b0, "disp12_a");
        check_display(1'b1, "disp12_b");
        check_period("scan");

        // 07: leading zero blanked on A only
        do_reset();
        for (int i = 0; i < 7; i++) step_model(1'b1, 1'b0, "inc7");
        check_display(1'b0, "disp07_a");
        check_display(1'b1, "disp07_b");

        // 10 -> 09 borrow
        do_reset();
        for (int i = 0; i < 10; i++) step_model(1'b1, 1'b0, "inc10");
        step_exp(1'b0, 1'b1, 9, 9, 1'b0, 1'b0, "borrow");

        // climb to 63, then press up: A wraps to 0, B saturates; both pulse wrap
        do_reset();
        for (int i = 0; i < 63; i++) step_model(1'b1, 1'b0, "climb");
        step_exp(1'b1, 1'b0, 0, 63, 1'b1, 1'b1, "top");

        // held increment for 100 cycles counts once
        ea = model_next(mod_a, 1'b1, 1'b0, 1'b1, wa);
        eb = model_next(mod_b, 1'b1, 1'b0, 1'b0, wb);
        wcnt_a = 0;
        wcnt_b = 0;
        inc = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            wcnt_a += int'(ifa.wrap);
            wcnt_b += int'(ifb.wrap);
        end
        chk("hold_a_cnt",   32'(ifa.count_bcd), 32'(to_bcd8(ea)));
        chk("hold_b_cnt",   32'(ifb.count_bcd), 32'(to_bcd8(eb)));
        chk("hold_a_wraps", 32'(wcnt_a), 32'(wa));
        chk("hold_b_wraps", 32'(wcnt_b), 32'(wb));
        inc = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mod_a = ea;
        mod_b = eb;

        // reset one cycle after an edge is registered: pending pulse discarded
        inc = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        inc   = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs("midreset");
        mod_a  = 0;
        mod_b  = 0;
        wcnt_a = 0;
        wcnt_b = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            wcnt_a += int'(ifa.wrap);
            wcnt_b += int'(ifb.wrap);
        end
        chk("midreset_a_hold", 32'(ifa.count_bcd), 32'd0);
        chk("midreset_b_hold", 32'(ifb.count_bcd), 32'd0);
        chk("midreset_wraps",  32'(wcnt_a + wcnt_b), 32'd0);

        // random presses against the reference model
        for (int r = 0; r < 60; r++) begin
            step_model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
            if (r % 15 == 14) begin
                check_display(1'b0, "rnd_disp_a");
                check_display(1'b1, "rnd_disp_b");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
